tdm_mux8x1: RTL
===============

// Module: tdm_mux8x1
// PURPOSE
//  8-to-1 time-division multiplexer: the transmit end of the 3-bit-select LED
//  distribution path. Snapshots eight 1-bit channels once per frame, then scans
//  them onto one serial data line. Each channel is held DWELL_CYCLES clocks.
//  The matching 3-bit select is emitted so a downstream 3-to-8 demux can rebuild
//  the eight channels.
// PARAMETERS
//  DWELL_CYCLES  25000000  clocks each channel is held; legal range >=1
//                          (default gives 0.5 s at 50 MHz)
//  CNT_W         25        dwell counter width; must hold DWELL_CYCLES-1
// PORTS
//  clk          in   1  system clock, all state on rising edge
//  rst_n        in   1  asynchronous active-low reset
//  enable       in   1  level; 1 = scan frames continuously, 0 = idle
//  in_1..in_8   in   1  channel inputs; in_1 maps to select 0, in_8 to select 7
//  data         out  1  snapshot value of the channel addressed by select
//  select       out  3  current channel index, 0..7
//  valid        out  1  1 while data/select carry a live channel
//  frame_start  out  1  one-cycle pulse on the first cycle of every frame
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE, data=0, select=0, valid=0,
//    frame_start=0, dwell counter=0, snapshot register=0.
//  - All outputs are registered. There are no combinational paths from inputs
//    to outputs.
//  - States: IDLE, SCAN.
//  - IDLE, enable=1 sampled at edge N:
//    - snap[7:0] <= {in_8..in_1}; state <= SCAN; select <= 0; cnt <= 0.
//    - At edge N: data <= in_1 as sampled, valid <= 1, frame_start <= 1.
//  - SCAN, each edge with enable=1:
//    - cnt < DWELL_CYCLES-1: cnt++; select/data unchanged; frame_start <= 0.
//    - cnt == DWELL_CYCLES-1 and select < 7: cnt <= 0; select++;
//      data <= snap[select+1].
//    - cnt == DWELL_CYCLES-1 and select == 7 (frame wrap):
//      - Re-snapshot all inputs; select <= 0; data <= new in_1.
//      - frame_start <= 1; cnt <= 0.
//  - Frame length is exactly 8*DWELL_CYCLES clocks. frame_start period equals
//    the frame length.
//  - Inputs are captured only at frame start. Input changes mid-frame do not
//    reach data until the next frame.
//  - DWELL_CYCLES=1: select advances every clock. frame_start pulses every 8th
//    clock.
//  - SCAN, enable=0 at any edge (including mid-dwell or at wrap):
//    - state <= IDLE; valid <= 0; data <= 0; select <= 0.
//    - frame_start <= 0; cnt <= 0; snap is retained.
//  - Re-enable from IDLE always starts a fresh frame at channel 0 with a new
//    snapshot. Scanning never resumes mid-frame.
//  - rst_n low mid-frame forces the reset values immediately, independent of clk.
// TESTING (DWELL_CYCLES=3 unless noted)
//  1. Reset:
//     rst_n=0 while in_*=1, enable=1 -> data=0, select=0, valid=0,
//     frame_start=0; no clk edge is needed.
//  2. Basic scan:
//     in_1..in_8 = 1,0,1,1,0,0,1,0; enable=1.
//     -> select walks 0..7, 3 clocks each.
//     -> data = 1,0,1,1,0,0,1,0; valid stays 1.
//     -> frame_start high on cycle 0 and cycle 24 only.
//  3. Snapshot isolation:
//     Toggle in_5 at cycle 5 of a frame -> data at select=4 shows the
//     pre-toggle value. The new value appears in the next frame.
//  4. Disable mid-frame:
//     Drop enable at select=3, cnt=1 -> next edge valid=0, data=0, select=0.
//     Re-enable -> frame_start=1, select=0.
//  5. DWELL_CYCLES=1:
//     -> select increments every clock 0..7,0.
//     -> frame_start pulses every 8 clocks.
//  6. Async reset mid-scan:
//     Pulse rst_n low between edges at select=6 -> outputs clear immediately.
//     After release with enable=1, the first edge starts a frame at select 0.

Source files
------------

// File: rtl/tdm_mux8x1.sv
// rtl/tdm_mux8x1.sv - 8-to-1 time-division multiplexer with per-frame snapshot and 3-bit select
module tdm_mux8x1 #(
    parameter int DWELL_CYCLES = 25000000,
    parameter int CNT_W        = 25
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       in_1,
    input  logic       in_2,
    input  logic       in_3,
    input  logic       in_4,
    input  logic       in_5,
    input  logic       in_6,
    input  logic       in_7,
    input  logic       in_8,
    output logic       data,
    output logic [2:0] select,
    output logic       valid,
    output logic       frame_start
);

    typedef enum logic {
        IDLE,
        SCAN
    } state_t;

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [7:0]       snap, snap_nxt;
    logic [2:0]       select_nxt;
    logic [2:0]       sel_inc;
    logic             data_nxt;
    logic             valid_nxt;
    logic             frame_start_nxt;
    logic [7:0]       ins;

    assign ins     = {in_8, in_7, in_6, in_5, in_4, in_3, in_2, in_1};
    assign sel_inc = select + 3'd1;

    always_comb begin
        state_nxt       = state;
        cnt_nxt         = cnt;
        snap_nxt        = snap;
        select_nxt      = select;
        data_nxt        = data;
        valid_nxt       = valid;
        frame_start_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_nxt       = SCAN;
                    snap_nxt        = ins;
                    select_nxt      = 3'd0;
                    cnt_nxt         = '0;
                    data_nxt        = in_1;
                    valid_nxt       = 1'b1;
                    frame_start_nxt = 1'b1;
                end
            end
            SCAN: begin
                if (!enable) begin
                    // Snapshot is kept; a later enable always takes a fresh one anyway.
                    state_nxt  = IDLE;
                    valid_nxt  = 1'b0;
                    data_nxt   = 1'b0;
                    select_nxt = 3'd0;
                    cnt_nxt    = '0;
                end else if (cnt != DWELL_LAST) begin
                    cnt_nxt = cnt + 1'b1;
                end else if (select != 3'd7) begin
                    cnt_nxt    = '0;
                    select_nxt = sel_inc;
                    data_nxt   = snap[sel_inc];
                end else begin
                    snap_nxt        = ins;
                    select_nxt      = 3'd0;
                    data_nxt        = in_1;
                    cnt_nxt         = '0;
                    frame_start_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            snap        <= 8'd0;
            select      <= 3'd0;
            data        <= 1'b0;
            valid       <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            snap        <= snap_nxt;
            select      <= select_nxt;
            data        <= data_nxt;
            valid       <= valid_nxt;
            frame_start <= frame_start_nxt;
        end
    end

endmodule
